status_beacon: RTL and testbench

STATUS_BEACON -- requirements
Module: status_beacon

---
 rtl/status_beacon.sv | 196 +++++++++++++++++++
 tb/tb_status_beacon.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_beacon.sv
// -----------------------------------------------------------------------------
// status_beacon
//
// Wishbone-slave status display. Software queues 16-bit status codes through
// the CODE register; a small FSM pops them one at a time and holds each code
// on io_out for a fixed number of cycles, so a fast burst of codes can still
// be seen on the pads or a logic analyser.
//
// Registers (byte addresses relative to BASE_ADR):
//   +0 CODE   W: enqueue dat[15:0] (dropped and ovf set when full)
//             R: {16'h0, io_out}
//   +4 STATUS R: bit0 empty, bit1 full, bit2 busy, bit3 ovf, bits[8:4] count
//             W: dat[3]=1 clears ovf
//   +8 CTRL   bit0 oe_en (R/W); write with bit1=1 flushes the queue,
//             bit1 always reads back 0
//
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   wbs_*               Wishbone classic slave (sel ignored)
//   io_out              displayed status code
//   io_oeb              active-low pad output enables, all equal to ~oe_en
// -----------------------------------------------------------------------------
module status_beacon #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0100,
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    localparam int PTR_W = $clog2(DEPTH);
    // Counter only ever holds HOLD_CYCLES-1 down to 0.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [4:0]       DEPTH_C   = 5'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [4:0]         count_q;
    logic [4:0]         count_d;
    logic               ovf_q;
    logic               oe_en_q;
    logic [15:0]        io_out_q;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic [15:0]        mem [DEPTH];

    logic        sel_code;
    logic        sel_status;
    logic        sel_ctrl;
    logic        accept;
    logic        wr_code;
    logic        queue_full;
    logic        queue_empty;
    logic        push;
    logic        pop;
    logic        flush;
    logic        busy;
    logic [31:0] rdata;

    // Byte select and the upper write-data half carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:16]};

    assign sel_code   = (wbs_adr_i == BASE_ADR);
    assign sel_status = (wbs_adr_i == BASE_ADR + 32'd4);
    assign sel_ctrl   = (wbs_adr_i == BASE_ADR + 32'd8);

    // The !ack term keeps a held strobe from being accepted twice.
    assign accept = wbs_cyc_i & wbs_stb_i & ~ack_q & (sel_code | sel_status | sel_ctrl);

    assign queue_full  = (count_q == DEPTH_C);
    assign queue_empty = (count_q == 5'd0);
    assign wr_code     = accept & wbs_we_i & sel_code;
    assign push        = wr_code & ~queue_full;
    assign flush       = accept & wbs_we_i & sel_ctrl & wbs_dat_i[1];
    // A flush wins over a pop so io_out keeps its current code.
    assign pop         = (state_q == IDLE) & ~queue_empty & ~flush;
    assign busy        = (state_q == HOLD);

    always_comb begin
        rdata = 32'h0;
        if (sel_code) begin
            rdata = {16'h0, io_out_q};
        end else if (sel_status) begin
            rdata = {23'h0, count_q, ovf_q, busy, queue_full, queue_empty};
        end else if (sel_ctrl) begin
            rdata = {31'h0, oe_en_q};
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 5'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wptr_q] <= wbs_dat_i[15:0];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= 5'd0;
            ovf_q      <= 1'b0;
            oe_en_q    <= 1'b0;
            io_out_q   <= 16'h0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
        end else begin
            ack_q   <= accept;
            dat_q   <= (accept & ~wbs_we_i) ? rdata : 32'h0;
            count_q <= count_d;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end

            if (wr_code & queue_full) begin
                ovf_q <= 1'b1;
            end else if (accept & wbs_we_i & sel_status & wbs_dat_i[3]) begin
                ovf_q <= 1'b0;
            end

            if (accept & wbs_we_i & sel_ctrl) begin
                oe_en_q <= wbs_dat_i[0];
            end

            if (flush) begin
                state_q    <= IDLE;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pop) begin
                            io_out_q   <= mem[rptr_q];
                            hold_cnt_q <= HOLD_LOAD;
                            state_q    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = io_out_q;
    assign io_oeb    = {16{~oe_en_q}};

endmodule

// File: tb/tb_status_beacon.sv
module tb_status_beacon;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int          D    = 4;
    localparam int          H    = 64;
    localparam logic [31:0] A_CODE = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_in;
    logic        ack;
    logic [31:0] dat_o;
    logic [15:0] io_out, io_oeb;

    int c_checks = 0;
    int c_errors = 0;

    // Reference model: queue contents, displayed code, remaining hold cycles.
    logic [15:0] m_q[$];
    logic [15:0] m_io;
    bit          m_oe, m_ovf, m_ack, m_ack_rd;
    int          m_left;
    logic [31:0] m_rd_exp;

    // io_out run-length tracker
    logic [15:0] run_val, last_val;
    int          run_len, last_len;

    status_beacon #(.BASE_ADR(BASE), .DEPTH(D), .HOLD_CYCLES(H)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_in),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        c_checks++;
        assert (obs === exp) else begin
            c_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == A_CODE) v = {16'h0, m_io};
        else if (a == A_STAT)
            v = {23'h0, 5'(m_q.size()), m_ovf, (m_left > 0), (m_q.size() == D), (m_q.size() == 0)};
        else if (a == A_CTRL) v = {31'h0, m_oe};
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_io = 16'h0; m_oe = 0; m_ovf = 0; m_ack = 0; m_ack_rd = 0; m_left = 0;
        m_rd_exp = 32'h0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic model_edge();
        bit hit, acc, fl, pop, push;
        int pre;
        hit = (adr == A_CODE) || (adr == A_STAT) || (adr == A_CTRL);
        acc = cyc && stb && !m_ack && hit;
        if (acc && !we) m_rd_exp = mread(adr);
        pre  = m_q.size();
        fl   = acc && we && (adr == A_CTRL) && dat_in[1];
        pop  = !fl && (m_left == 0) && (pre > 0);
        push = acc && we && (adr == A_CODE) && (pre < D);
        if (acc && we && adr == A_CODE && pre >= D) m_ovf = 1;
        if (acc && we && adr == A_STAT && dat_in[3]) m_ovf = 0;
        if (acc && we && adr == A_CTRL) m_oe = dat_in[0];
        if (fl) begin
            m_q.delete();
            m_left = 0;
        end else begin
            if (pop) begin
                m_io   = m_q.pop_front();
                m_left = H;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (push) m_q.push_back(dat_in[15:0]);
        end
        m_ack    = acc;
        m_ack_rd = acc && !we;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("io_out", {16'h0, io_out}, {16'h0, m_io});
        chk("io_oeb", {16'h0, io_oeb}, {16'h0, {16{~m_oe}}});
        chk("ack", {31'h0, ack}, {31'h0, m_ack});
        if (m_ack_rd) chk("rdata", dat_o, m_rd_exp);
        if (io_out !== run_val) begin
            last_val = run_val; last_len = run_len;
            run_val = io_out; run_len = 1;
        end else begin
            run_len++;
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output bit got);
        cyc = 1; stb = 1; we = w; adr = a; dat_in = d; sel = 4'($urandom_range(0, 15));
        got = 0; rd = 32'h0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (ack === 1'b1) begin
                got = 1;
                rd  = dat_o;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; bit g;
        bus(1, a, d, r, g);
        chk("wr_ack", {31'h0, g}, 32'h1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bit g;
        bus(0, a, 32'h0, r, g);
        chk("rd_ack", {31'h0, g}, 32'h1);
    endtask

    initial begin
        logic [31:0] r;
        bit          g;
        int          sel_r;
        logic [31:0] a, d;

        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_in = 0;
        run_val = 16'h0; run_len = 0; last_val = 16'h0; last_len = 0;
        model_reset();
        repeat (3) tick();
        rst = 0;
        chk("rst_io_out", {16'h0, io_out}, 32'h0);
        chk("rst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("rst_dat_o", dat_o, 32'h0);
        rd(A_STAT, r);
        chk("rst_status", r, 32'h1);

        // Enable pads, show one code; it appears on the edge after the accept
        wr(A_CTRL, 32'h1);
        chk("oeb_on", {16'h0, io_oeb}, 32'h0);
        wr(A_CODE, 32'h0000_AB60);
        chk("code_before_pop", {16'h0, io_out}, 32'h0);
        tick();
        chk("code_shown", {16'h0, io_out}, 32'h0000_AB60);
        rd(A_STAT, r);
        chk("busy_status", r, 32'h0000_0005);

        // Second code queued behind the first; first shown exactly H+1 cycles
        wr(A_CODE, 32'h0000_AB61);
        for (int i = 0; i < 200 && io_out !== 16'hAB61; i++) tick();
        chk("ab61_shown", {16'h0, io_out}, 32'h0000_AB61);
        chk("ab60_run_val", {16'h0, last_val}, 32'h0000_AB60);
        chk("ab60_run_len", last_len, 32'(H + 1));
        repeat (H + 4) tick();
        rd(A_STAT, r);
        chk("idle_status", r, 32'h1);

        // Overflow while holding
        wr(A_CODE, 32'h0000_1111);
        tick();
        for (int i = 0; i < 5; i++) wr(A_CODE, 32'h0000_2000 + 32'(i));
        rd(A_STAT, r);
        chk("ovf_status", r, 32'h0000_004E);
        wr(A_STAT, 32'h8);
        rd(A_STAT, r);
        chk("ovf_cleared", r, 32'h0000_0046);

        // Flush mid-hold
        wr(A_CTRL, 32'h3);
        rd(A_STAT, r);
        chk("flush_status", r, 32'h1);
        rd(A_CTRL, r);
        chk("flush_ctrl", r, 32'h1);
        chk("flush_io_keep", {16'h0, io_out}, 32'h0000_1111);
        repeat (150) tick();
        chk("flush_no_more", {16'h0, io_out}, 32'h0000_1111);

        // Unmapped addresses
        bus(1, BASE + 32'd12, 32'h3, r, g);
        chk("noack_p12", {31'h0, g}, 32'h0);
        bus(1, BASE - 32'd4, 32'h3, r, g);
        chk("noack_m4", {31'h0, g}, 32'h0);
        bus(0, BASE + 32'd12, 32'h0, r, g);
        chk("noack_rd", {31'h0, g}, 32'h0);
        rd(A_CTRL, r);
        chk("ctrl_intact", r, 32'h1);
        rd(A_STAT, r);
        chk("stat_intact", r, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            sel_r = $urandom_range(0, 9);
            if (sel_r <= 4) begin
                a = A_CODE; d = $urandom;
            end else if (sel_r <= 6) begin
                a = A_STAT; d = $urandom;
            end else if (sel_r == 7) begin
                a = A_CTRL;
                d = {30'h0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
            end else if (sel_r == 8) begin
                a = BASE + 32'd12; d = $urandom;
            end else begin
                a = BASE - 32'd4; d = $urandom;
            end
            bus(1'($urandom_range(0, 1)), a, d, r, g);
            if (sel_r <= 7) chk("rand_ack", {31'h0, g}, 32'h1);
            repeat ($urandom_range(0, 40)) tick();
        end

        // Asynchronous reset during HOLD with a request outstanding
        wr(A_CTRL, 32'h1);
        wr(A_CODE, 32'h0000_5A5A);
        repeat (4) tick();
        cyc = 1; stb = 1; we = 0; adr = A_STAT; dat_in = 0;
        #2;
        rst = 1;
        #1;
        chk("arst_ack", {31'h0, ack}, 32'h0);
        chk("arst_io_out", {16'h0, io_out}, 32'h0);
        chk("arst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("arst_dat_o", dat_o, 32'h0);
        model_reset();
        repeat (2) tick();
        rst = 0;
        tick();
        chk("post_rst_ack", {31'h0, ack}, 32'h1);
        chk("post_rst_status", dat_o, 32'h1);
        cyc = 0; stb = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", c_checks, c_errors);
        $finish;
    end

endmodule
